// File: rtl/cpu_trace_buffer_pkg.sv
// Shared definitions for the CPU execution trace unit: capture state encoding
// and width helpers used by the top level and the trace storage.
package cpu_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int entry_w(input int pc_w, input int instr_w, input int data_w);
    return pc_w + instr_w + data_w;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace entry storage: one synchronous write port, one registered read port.
module cpu_trace_buffer_ram
  import cpu_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage carries no reset; consumers qualify rdata with their own valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Triggered execution trace: circular capture of retired instructions with a
// pre-trigger history and a programmable post-trigger window, frozen for readout.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int DATA_W    = 32,
  parameter int POST_TRIG = 8,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               force_trig,
  input  logic               retire,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  result_in,
  output logic               armed,
  output logic               triggered,
  output logic               done,
  output logic [CW-1:0]      count,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_idx,
  output logic               rd_valid,
  output logic               rd_err,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [DATA_W-1:0]  rd_result
);

  localparam int EW     = entry_w(PC_W, INSTR_W, DATA_W);
  localparam int PW_RAW = clog2(POST_TRIG + 1);
  localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   post_q, post_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_err_q, rd_err_d;

  logic            capturing;
  logic            trig_fire;
  logic            wr_en;
  logic            post_last;
  logic            rd_ok;
  logic [AW-1:0]   rd_addr;
  logic [EW-1:0]   rdata;

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  // arm has priority: a same-cycle trigger or retire is dropped.
  assign trig_fire = (state_q == ST_ARMED) && !arm &&
                     ((retire && trig_en && (pc_in == trig_pc)) || force_trig);
  assign wr_en     = capturing && retire && !arm;
  assign post_last = (state_q == ST_POST) && wr_en && (post_q == PW'(1));

  // Oldest entry sits count positions behind the write pointer.
  assign rd_ok   = rd_req && (state_q == ST_DONE) && ({1'b0, rd_idx} < count_q);
  assign rd_addr = wr_ptr_q - count_q[AW-1:0] + rd_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (trig_fire) state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        ST_POST:  if (post_last) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    armed     = 1'b0;
    triggered = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_ARMED: armed = 1'b1;
      ST_POST: begin
        armed     = 1'b1;
        triggered = 1'b1;
      end
      ST_DONE: begin
        triggered = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    if (arm) begin
      wr_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
      end
      if (trig_fire)                         post_d = PW'(POST_TRIG);
      else if ((state_q == ST_POST) && wr_en) post_d = post_q - PW'(1);
    end
  end

  always_comb begin
    rd_valid_d = rd_ok;
    rd_err_d   = rd_req && !rd_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  cpu_trace_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({pc_in, instr_in, result_in}),
    .re_i    (rd_ok),
    .raddr_i (rd_addr),
    .rdata_o (rdata)
  );

  // Read data is forced to zero unless the response is a valid hit.
  always_comb begin
    count     = count_q;
    rd_valid  = rd_valid_q;
    rd_err    = rd_err_q;
    rd_pc     = '0;
    rd_instr  = '0;
    rd_result = '0;
    if (rd_valid_q) begin
      rd_pc     = rdata[EW-1 -: PC_W];
      rd_instr  = rdata[DATA_W +: INSTR_W];
      rd_result = rdata[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: two instances (POST_TRIG 8 and 0) share stimulus.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        reset, arm, trig_en, force_trig, retire, rd_req;
  logic [31:0] trig_pc, pc_in, instr_in, result_in;
  logic [3:0]  rd_idx;

  logic        armed_a, triggered_a, done_a, rd_valid_a, rd_err_a;
  logic [4:0]  count_a;
  logic [31:0] rd_pc_a, rd_instr_a, rd_result_a;
  logic        armed_b, triggered_b, done_b, rd_valid_b, rd_err_b;
  logic [4:0]  count_b;
  logic [31:0] rd_pc_b, rd_instr_b, rd_result_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [97:0] sb[$];
  logic [97:0] exp_v;
  logic        sel_b = 1'b0;
  logic [97:0] obs;

  assign obs = sel_b ? {rd_valid_b, rd_err_b, rd_pc_b, rd_instr_b, rd_result_b}
                     : {rd_valid_a, rd_err_a, rd_pc_a, rd_instr_a, rd_result_a};

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH(16), .PC_W(32), .INSTR_W(32), .DATA_W(32), .POST_TRIG(8)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .force_trig(force_trig), .retire(retire), .pc_in(pc_in), .instr_in(instr_in),
    .result_in(result_in), .armed(armed_a), .triggered(triggered_a), .done(done_a),
    .count(count_a), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid_a),
    .rd_err(rd_err_a), .rd_pc(rd_pc_a), .rd_instr(rd_instr_a), .rd_result(rd_result_a));

  cpu_trace_buffer #(.DEPTH(16), .PC_W(32), .INSTR_W(32), .DATA_W(32), .POST_TRIG(0)) dut0 (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .force_trig(force_trig), .retire(retire), .pc_in(pc_in), .instr_in(instr_in),
    .result_in(result_in), .armed(armed_b), .triggered(triggered_b), .done(done_b),
    .count(count_b), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid_b),
    .rd_err(rd_err_b), .rd_pc(rd_pc_b), .rd_instr(rd_instr_b), .rd_result(rd_result_b));

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic [31:0] res_of(input logic [31:0] pc);
    return pc * 3 + 32'h11;
  endfunction

  function automatic logic [97:0] exp_rd(input logic [31:0] pc, input logic err);
    if (err) return {1'b0, 1'b1, 96'd0};
    return {1'b1, 1'b0, pc, instr_of(pc), res_of(pc)};
  endfunction

  task automatic drive(input logic r, input logic [31:0] pc, input logic f, input logic a);
    @(negedge clk);
    retire     = r;
    pc_in      = pc;
    instr_in   = instr_of(pc);
    result_in  = res_of(pc);
    force_trig = f;
    arm        = a;
    rd_req     = 1'b0;
  endtask

  task automatic rd_issue(input logic [3:0] idx, input logic [97:0] e);
    @(negedge clk);
    retire     = 1'b0;
    force_trig = 1'b0;
    arm        = 1'b0;
    rd_req     = 1'b1;
    rd_idx     = idx;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0; arm = 0; trig_en = 0; force_trig = 0; retire = 0; rd_req = 0;
    trig_pc = 0; pc_in = 0; instr_in = 0; result_in = 0; rd_idx = 0;
    #1;
    n_cmp++;
    if ({armed_a, triggered_a, done_a, count_a, obs} !== '0) begin
      n_bad++; $display("FAIL reset_init got=%b/%0d exp=all zero", {armed_a, triggered_a, done_a}, count_a);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 32'h1000 + i * 4, 0, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (count_a !== 5'd5) begin n_bad++; $display("FAIL reset_precount got=%0d exp=5", count_a); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({armed_a, count_a, obs} !== '0) begin
      n_bad++; $display("FAIL reset_async got armed=%b count=%0d rd=%h exp=0", armed_a, count_a, obs);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 32'h2000, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
    if ({armed_a, triggered_a, done_a, count_a} !== '0) begin
      n_bad++; $display("FAIL reset_idle got flags=%b count=%0d exp=000/0", {armed_a, triggered_a, done_a}, count_a);
    end
  endtask

  task automatic test_pc_trigger();
    trig_en = 1'b1; trig_pc = 32'h20; sel_b = 1'b0;
    drive(0, 0, 0, 1);
    for (int i = 0; i <= 16; i++) begin
      drive(1, i * 4, 0, 0);
      if (i == 7 || i == 8 || i == 16) begin
        @(posedge clk); #1;
        n_cmp++;
        if (i == 7 && {triggered_a, count_a} !== {1'b0, 5'd8}) begin
          n_bad++; $display("FAIL pc_pre got trig=%b count=%0d exp=0/8", triggered_a, count_a);
        end else if (i == 8 && {triggered_a, done_a, count_a} !== {2'b10, 5'd9}) begin
          n_bad++; $display("FAIL pc_hit got trig=%b done=%b count=%0d exp=1/0/9", triggered_a, done_a, count_a);
        end else if (i == 16 && {done_a, count_a} !== {1'b1, 5'd16}) begin
          n_bad++; $display("FAIL pc_done got done=%b count=%0d exp=1/16", done_a, count_a);
        end
      end
    end
    drive(1, 32'h44, 0, 0);
    drive(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] idx;
      idx = (k == 0) ? 4'd0 : (k == 1) ? 4'd7 : 4'd15;
      rd_issue(idx, exp_rd(32'h04 + idx * 4, 1'b0));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL pc_read idx=%0d got=%h exp=%h", idx, obs, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    trig_pc = 32'hA0; sel_b = 1'b0;
    drive(0, 0, 0, 1);
    for (int i = 0; i <= 48; i++) begin
      if (i % 7 == 3) drive(0, 32'hFFFF_0000, 0, 0);
      drive(1, i * 4, 0, 0);
    end
    drive(0, 0, 0, 0);
    n_cmp++;
    if ({done_a, count_a} !== {1'b1, 5'd16}) begin
      n_bad++; $display("FAIL wrap_done got done=%b count=%0d exp=1/16", done_a, count_a);
    end
    for (int i = 0; i < 16; i++) begin
      rd_issue(4'(i), exp_rd(32'h84 + i * 4, 1'b0));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_read idx=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (obs[97:96] !== 2'b00) begin n_bad++; $display("FAIL rd_one_cycle got=%b exp=00", obs[97:96]); end
  endtask

  task automatic test_force_post0();
    trig_en = 1'b0; sel_b = 1'b1;
    drive(0, 0, 0, 1);
    drive(1, 32'h100, 0, 0);
    drive(1, 32'h104, 0, 0);
    drive(1, 32'h108, 1, 0);
    @(posedge clk); #1;
    n_cmp++;
    if ({done_b, count_b, triggered_a, done_a} !== {1'b1, 5'd3, 2'b10}) begin
      n_bad++; $display("FAIL force_done got b_done=%b b_count=%0d a_trig=%b a_done=%b exp=1/3/1/0",
                        done_b, count_b, triggered_a, done_a);
    end
    drive(1, 32'h10C, 0, 0);
    drive(1, 32'h110, 1, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if (count_b !== 5'd3) begin n_bad++; $display("FAIL force_frozen got=%0d exp=3", count_b); end
    for (int k = 0; k < 3; k++) begin
      logic [3:0] idx;
      idx = (k == 0) ? 4'd2 : (k == 1) ? 4'd0 : 4'd5;
      rd_issue(idx, exp_rd(32'h100 + idx * 4, idx == 4'd5));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL force_read idx=%0d got=%h exp=%h", idx, obs, exp_v); end
    end
  endtask

  task automatic test_rd_err_armed();
    sel_b = 1'b0;
    drive(0, 0, 0, 1);
    drive(1, 32'h180, 0, 0);
    rd_issue(4'd0, exp_rd(32'h0, 1'b1));
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_cmp++;
    if ({armed_a, obs} !== {1'b1, exp_v}) begin
      n_bad++; $display("FAIL err_armed got armed=%b rd=%h exp=1/%h", armed_a, obs, exp_v);
    end
  endtask

  task automatic test_rearm();
    sel_b = 1'b1; trig_en = 1'b0;
    drive(0, 0, 0, 1);
    drive(1, 32'h200, 0, 0);
    drive(1, 32'h204, 1, 0);
    drive(0, 0, 0, 0);
    rd_issue(4'd1, exp_rd(32'h204, 1'b0));
    arm = 1'b1;
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rearm_pending_read got=%h exp=%h", obs, exp_v); end
    n_cmp++;
    if ({armed_b, triggered_b, count_b} !== {2'b10, 5'd0}) begin
      n_bad++; $display("FAIL rearm_state got armed=%b trig=%b count=%0d exp=1/0/0", armed_b, triggered_b, count_b);
    end
    trig_en = 1'b1; trig_pc = 32'h300;
    drive(1, 32'h300, 1, 1);
    @(posedge clk); #1;
    n_cmp++;
    if ({armed_b, triggered_b, count_b, armed_a, triggered_a} !== {2'b10, 5'd0, 2'b10}) begin
      n_bad++; $display("FAIL arm_wins got b=%b/%b/%0d a=%b/%b exp=1/0/0 1/0",
                        armed_b, triggered_b, count_b, armed_a, triggered_a);
    end
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    n_cmp++;
    if ({triggered_a, done_a, count_a, done_b, count_b} !== {2'b10, 5'd0, 1'b1, 5'd0}) begin
      n_bad++; $display("FAIL force_no_retire got a=%b/%b/%0d b_done=%b b_count=%0d exp=1/0/0 1/0",
                        triggered_a, done_a, count_a, done_b, count_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pc_trigger();
    test_back_to_back();
    test_force_post0();
    test_rd_err_armed();
    test_rearm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
